// File: rtl/cordic_vector.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vector
// Description : Iterative 16-stage CORDIC in vectoring mode. Converts a
//               Q2.20 Cartesian vector (x, y) into its angle atan2(y, x)
//               (Q3.20 radians) and its gain-scaled magnitude K*|v| (Q4.20).
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_vector (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [21:0]  x_in,
  input  logic signed [21:0]  y_in,
  output logic                busy,
  output logic                done,
  output logic signed [22:0]  angle_out,
  output logic signed [23:0]  mag_out
);

  localparam logic [0:0]         S_IDLE = 1'b0;
  localparam logic [0:0]         S_ITER = 1'b1;
  localparam logic [3:0]         LAST_ITER = 4'd15;
  localparam logic signed [22:0] PI_2 = 23'sd1647099;

  // round(atan(2^-i) * 2^20)
  function automatic logic signed [22:0] atan_lut(input logic [3:0] idx);
    logic signed [22:0] v;
    case (idx)
      4'd0:    v = 23'sd823550;
      4'd1:    v = 23'sd486170;
      4'd2:    v = 23'sd256879;
      4'd3:    v = 23'sd130396;
      4'd4:    v = 23'sd65451;
      4'd5:    v = 23'sd32757;
      4'd6:    v = 23'sd16383;
      4'd7:    v = 23'sd8192;
      4'd8:    v = 23'sd4096;
      4'd9:    v = 23'sd2048;
      4'd10:   v = 23'sd1024;
      4'd11:   v = 23'sd512;
      4'd12:   v = 23'sd256;
      4'd13:   v = 23'sd128;
      4'd14:   v = 23'sd64;
      default: v = 23'sd32;
    endcase
    return v;
  endfunction

  logic [0:0]         state_q, state_d;
  logic [3:0]         iter_q, iter_d;
  logic signed [23:0] x_q, x_d;
  logic signed [23:0] y_q, y_d;
  logic signed [22:0] z_q, z_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
  logic signed [22:0] angle_q, angle_d;
  logic signed [23:0] mag_q, mag_d;

  logic signed [23:0] w_x_sx, w_y_sx;
  logic signed [23:0] w_x_sh, w_y_sh;
  logic signed [23:0] w_x_nxt, w_y_nxt;
  logic signed [22:0] w_z_nxt, w_atan;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: accept start only when idle, leave after the last iteration
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ITER;
      S_ITER:  if (iter_q == LAST_ITER) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == S_ITER);
  end

  // One micro-rotation step, driving y toward zero using previous-cycle x/y
  always_comb begin
    w_x_sx = {{2{x_in[21]}}, x_in};
    w_y_sx = {{2{y_in[21]}}, y_in};
    w_x_sh = x_q >>> iter_q;
    w_y_sh = y_q >>> iter_q;
    w_atan = atan_lut(iter_q);
    if (!y_q[23]) begin
      w_x_nxt = x_q + w_y_sh;
      w_y_nxt = y_q - w_x_sh;
      w_z_nxt = z_q + w_atan;
    end else begin
      w_x_nxt = x_q - w_y_sh;
      w_y_nxt = y_q + w_x_sh;
      w_z_nxt = z_q - w_atan;
    end
  end

  // Datapath next-state: capture with quadrant pre-rotation, iterate, publish
  always_comb begin
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    angle_d = angle_q;
    mag_d   = mag_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        iter_d = 4'd0;
        zero_d = (x_in == 22'sd0) && (y_in == 22'sd0);
        if (!x_in[21]) begin
          x_d = w_x_sx;
          y_d = w_y_sx;
          z_d = 23'sd0;
        end else if (!y_in[21]) begin
          // rotate by -90 degrees, credit +pi/2
          x_d = w_y_sx;
          y_d = -w_x_sx;
          z_d = PI_2;
        end else begin
          // rotate by +90 degrees, credit -pi/2
          x_d = -w_y_sx;
          y_d = w_x_sx;
          z_d = -PI_2;
        end
      end
    end else begin
      x_d    = w_x_nxt;
      y_d    = w_y_nxt;
      z_d    = w_z_nxt;
      iter_d = iter_q + 4'd1;
      if (iter_q == LAST_ITER) begin
        done_d  = 1'b1;
        iter_d  = 4'd0;
        angle_d = zero_q ? 23'sd0 : w_z_nxt;
        mag_d   = zero_q ? 24'sd0 : w_x_nxt;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter_q  <= 4'd0;
      x_q     <= 24'sd0;
      y_q     <= 24'sd0;
      z_q     <= 23'sd0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      angle_q <= 23'sd0;
      mag_q   <= 24'sd0;
    end else begin
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign done      = done_q;
  assign angle_out = angle_q;
  assign mag_out   = mag_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_vector.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_vector
// Description : Directed self-checking bench for cordic_vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_vector;

  logic               clk;
  logic               reset;
  logic               start;
  logic signed [21:0] x_in;
  logic signed [21:0] y_in;
  logic               busy;
  logic               done;
  logic signed [22:0] angle_out;
  logic signed [23:0] mag_out;

  int n_tests;
  int n_fail;

  cordic_vector dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .angle_out (angle_out),
    .mag_out   (mag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int absd(input int a, input int b);
    int d;
    d = a - b;
    return (d < 0) ? -d : d;
  endfunction

  // Pulse start for one capture edge, then wait (bounded) for done.
  // lat = number of rising edges from the capture edge to done; -1 on timeout.
  task automatic do_conv(input int xv, input int yv, output int ang, output int mg, output int lat);
    logic [31:0] xb, yb;
    xb = xv;
    yb = yv;
    @(negedge clk);
    x_in  = xb[21:0];
    y_in  = yb[21:0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    ang = int'(angle_out);
    mg  = int'(mag_out);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || angle_out !== 23'sd0 || mag_out !== 24'sd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b angle=%0d mag=%0d, required all 0",
               busy, done, angle_out, mag_out);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_axis;
    int a, m, l;
    do_conv(1048576, 0, a, m, l);
    n_tests++;
    if (l != 16) begin
      n_fail++;
      $display("FAIL axis_latency: got %0d cycles, required 16", l);
    end
    n_tests++;
    if (absd(a, 0) > 64) begin
      n_fail++;
      $display("FAIL axis_angle: got %0d, required 0 +/-64", a);
    end
    n_tests++;
    if (absd(m, 1726720) > 128) begin
      n_fail++;
      $display("FAIL axis_mag: got %0d, required 1726720 +/-128", m);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width: done=%b busy=%b one cycle after done, required 0/0", done, busy);
    end
  endtask

  task automatic test_quadrants;
    int a, m, l;
    do_conv(0, 1048576, a, m, l);
    n_tests++;
    if (l != 16 || absd(a, 1647099) > 64) begin
      n_fail++;
      $display("FAIL q_pos_y_angle: got %0d (lat %0d), required 1647099 +/-64", a, l);
    end
    do_conv(-1048576, 0, a, m, l);
    n_tests++;
    if (l != 16 || absd(a, 3294199) > 64) begin
      n_fail++;
      $display("FAIL q_neg_x_angle: got %0d (lat %0d), required 3294199 +/-64", a, l);
    end
    do_conv(-1048576, -1048576, a, m, l);
    n_tests++;
    if (l != 16 || absd(a, -2470649) > 64) begin
      n_fail++;
      $display("FAIL q3_angle: got %0d (lat %0d), required -2470649 +/-64", a, l);
    end
    n_tests++;
    if (absd(m, 2442000) > 128) begin
      n_fail++;
      $display("FAIL q3_mag: got %0d, required 2442000 +/-128", m);
    end
  endtask

  task automatic test_extremes;
    int a, m, l;
    do_conv(-2097152, -2097152, a, m, l);
    n_tests++;
    if (l != 16 || absd(a, -2470649) > 64) begin
      n_fail++;
      $display("FAIL ext_angle: got %0d (lat %0d), required -2470649 +/-64", a, l);
    end
    n_tests++;
    if (absd(m, 4884000) > 256) begin
      n_fail++;
      $display("FAIL ext_mag: got %0d, required 4884000 +/-256", m);
    end
    do_conv(0, 0, a, m, l);
    n_tests++;
    if (l != 16 || a != 0 || m != 0) begin
      n_fail++;
      $display("FAIL zero_vec: angle=%0d mag=%0d lat=%0d, required 0/0/16", a, m, l);
    end
  endtask

  task automatic test_ignore_start;
    int dones, first;
    int la;
    logic [31:0] xb;
    logic [31:0] yb;
    xb = 0;
    yb = -1048576;
    dones = 0;
    first = -1;
    @(negedge clk);
    x_in  = 22'sd1048576;
    y_in  = 22'sd1048576;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    // inputs change after capture and must not matter
    x_in  = xb[21:0];
    y_in  = yb[21:0];
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = (c == 3 || c == 10) ? 1'b1 : 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (first < 0) first = c;
      end
    end
    n_tests++;
    if (dones != 1 || first != 16) begin
      n_fail++;
      $display("FAIL ignore_start: %0d done pulses first at %0d, required 1 at 16", dones, first);
    end
    la = int'(angle_out);
    n_tests++;
    if (absd(la, 823550) > 64) begin
      n_fail++;
      $display("FAIL ignore_start_angle: got %0d, required 823550 +/-64", la);
    end
  endtask

  task automatic test_back_to_back;
    int a, m, l, gap;
    logic [31:0] yb;
    yb = 1048576;
    do_conv(1048576, 0, a, m, l);
    // done is high now: request the next conversion in this same cycle
    x_in  = 22'sd0;
    y_in  = yb[21:0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    gap = -1;
    for (int c = 2; c <= 45; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        gap = c;
        break;
      end
    end
    n_tests++;
    if (l != 16 || gap != 17) begin
      n_fail++;
      $display("FAIL back_to_back_gap: got %0d cycles, required 17", gap);
    end
    a = int'(angle_out);
    n_tests++;
    if (absd(a, 1647099) > 64) begin
      n_fail++;
      $display("FAIL back_to_back_angle: got %0d, required 1647099 +/-64", a);
    end
  endtask

  task automatic test_hold;
    int a, m, l, bad;
    logic signed [22:0] ha;
    logic signed [23:0] hm;
    do_conv(-1048576, -1048576, a, m, l);
    ha = angle_out;
    hm = mag_out;
    bad = 0;
    x_in = 22'sd12345;
    y_in = -22'sd54321;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (angle_out !== ha || mag_out !== hm || done !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0 || absd(int'(ha), -2470649) > 64) begin
      n_fail++;
      $display("FAIL output_hold: %0d unstable cycles, angle=%0d, required 0 and -2470649", bad, ha);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    @(negedge clk);
    x_in  = 22'sd1048576;
    y_in  = 22'sd0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || angle_out !== 23'sd0 || mag_out !== 24'sd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b angle=%0d mag=%0d, required all 0",
               busy, done, angle_out, mag_out);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: %0d cycles with done/busy after abort, required 0", dones);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    x_in    = 22'sd0;
    y_in    = 22'sd0;
    test_reset();
    test_axis();
    test_quadrants();
    test_extremes();
    test_ignore_start();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
